ip_rx: RTL

- IPv4 receive stage that sits directly upstream of the UDP receive stage.
- Consumes the Ethernet payload stream from the MAC receive stage and validates the 20-byte IPv4 header.
- Strips the header and realigns the payload (it starts at byte 20, a 4-byte offset) so the transport header lands at byte 0 of the first output beat.
- Emits the payload with a 56-bit user sideband: {payload length, protocol, source IP}.

---
 rtl/ip_pkg.sv | 48 ++++
 rtl/ip_hdr_csum.sv | 26 ++
 rtl/ip_rx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ip_pkg.sv
// Shared IPv4 receive definitions: header constants, FSM encoding, user sideband layout.
// Latency: n/a (package). Backpressure: n/a.
// The UDP receive stage imports the same user-field offsets.
package ip_pkg;

    localparam logic [3:0]  IPV4_VERSION   = 4'd4;
    localparam logic [3:0]  IPV4_IHL_MIN   = 4'd5;
    localparam logic [15:0] IPV4_HDR_BYTES = 16'd20;
    localparam logic [15:0] IPV4_MIN_TOTAL = 16'd28;
    localparam logic [15:0] IPV4_MAX_TOTAL = 16'd1500;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;
    localparam logic [31:0] IP_BROADCAST   = 32'hFFFF_FFFF;

    // m_axis_ip_user layout: {payload length[15:0], protocol[7:0], source IP[31:0]}
    localparam int LEN_MSB   = 55;
    localparam int PROTO_MSB = 39;
    localparam int SRCIP_MSB = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_FLUSH,
        ST_DROP
    } ip_rx_state_e;

    // Number of enabled bytes in an MSB-first contiguous keep vector.
    function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, keep[i]};
        end
        return n;
    endfunction

    // MSB-first mask covering n bytes; n >= 8 gives all ones.
    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [7:0] m;
        if (n >= 4'd8) begin
            m = 8'hFF;
        end else begin
            m = ~(8'hFF >> n);
        end
        return m;
    endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// Ones-complement adder folding a running header sum with 2 or 4 halfwords of a beat.
// Latency: combinational. Backpressure: none.
// Only built when IP_RX_CHECKSUM_EN is defined.
`ifdef IP_RX_CHECKSUM_EN
module ip_hdr_csum (
    input  logic [15:0] acc_i,
    input  logic [63:0] dat_i,
    input  logic        lo_en_i,
    output logic [15:0] sum_o
);

    logic [18:0] raw;
    logic [16:0] fold1;

    always_comb begin
        raw = {3'd0, acc_i} + {3'd0, dat_i[63:48]} + {3'd0, dat_i[47:32]};
        if (lo_en_i) begin
            raw = raw + {3'd0, dat_i[31:16]} + {3'd0, dat_i[15:0]};
        end
        // Two end-around-carry folds are enough for at most five 16-bit terms.
        fold1 = {1'b0, raw[15:0]} + {14'd0, raw[18:16]};
        sum_o = fold1[15:0] + {15'd0, fold1[16]};
    end

endmodule
`endif

// File: rtl/ip_rx.sv
// IPv4 receive: validates the 20-byte header, strips it, realigns payload by 4 bytes (option IP_RX_CHECKSUM_EN).
// Latency: first output beat 2 cycles after input beat 3; registered input and registered outputs.
// Backpressure: none; input has no ready and output beats are assumed always accepted.
module ip_rx
    import ip_pkg::*;
#(
    parameter logic [31:0] P_LOCAL_IP     = 32'hC0A8_6401,
    parameter logic [7:0]  P_ACCEPT_PROTO = PROTO_UDP
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_dynamic_local_ip,
    input  logic        i_dynamic_local_valid,
    input  logic [63:0] s_axis_mac_data,
    input  logic [7:0]  s_axis_mac_keep,
    input  logic        s_axis_mac_last,
    input  logic        s_axis_mac_valid,
    output logic [63:0] m_axis_ip_data,
    output logic [55:0] m_axis_ip_user,
    output logic [7:0]  m_axis_ip_keep,
    output logic        m_axis_ip_last,
    output logic        m_axis_ip_valid,
    output logic        o_drop
);

    logic [63:0]  in_dat_q;
    logic [7:0]   in_keep_q;
    logic         in_last_q, in_vld_q, resync_q;
    logic         in_vld_d;
    logic [31:0]  local_ip_q;

    ip_rx_state_e state_q;
    logic [1:0]   hcnt_q;
    logic [15:0]  tot_len_q;
    logic         hdr0_ok_q;
    logic [7:0]   proto_q;
    logic [31:0]  src_q;
    logic [31:0]  hold_q;
    logic [15:0]  len_q, cnt_q;
    logic [2:0]   flush_n_q;

    logic [63:0]  dat_q;
    logic [55:0]  user_q;
    logic [7:0]   keep_q;
    logic         last_q, vld_q, drop_q;

    logic         hdr0_ok, dst_ok, len_ok, csum_ok, accept, fits;
    logic [3:0]   n_in, n_hi, avail;
    logic [15:0]  rem, payload_len;
    logic [63:0]  out_beat;

    // After reset the MAC may still be mid-frame: swallow beats until an idle cycle or a last.
    assign in_vld_d = s_axis_mac_valid & ~resync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_dat_q   <= '0;
            in_keep_q  <= '0;
            in_last_q  <= 1'b0;
            in_vld_q   <= 1'b0;
            resync_q   <= 1'b1;
            local_ip_q <= P_LOCAL_IP;
        end else begin
            in_vld_q  <= in_vld_d;
            in_last_q <= in_vld_d & s_axis_mac_last;
            if (in_vld_d) begin
                in_dat_q  <= s_axis_mac_data;
                in_keep_q <= s_axis_mac_keep;
            end
            if (!s_axis_mac_valid || s_axis_mac_last) begin
                resync_q <= 1'b0;
            end
            if (i_dynamic_local_valid) begin
                local_ip_q <= i_dynamic_local_ip;
            end
        end
    end

    always_comb begin
        hdr0_ok     = (in_dat_q[63:60] == IPV4_VERSION) && (in_dat_q[59:56] == IPV4_IHL_MIN) &&
                      !in_dat_q[13] && (in_dat_q[12:0] == 13'd0);
        dst_ok      = (in_dat_q[63:32] == local_ip_q) || (in_dat_q[63:32] == IP_BROADCAST);
        len_ok      = (tot_len_q >= IPV4_MIN_TOTAL) && (tot_len_q <= IPV4_MAX_TOTAL);
        accept      = hdr0_ok_q && (proto_q == P_ACCEPT_PROTO) && dst_ok && len_ok && csum_ok;
        payload_len = tot_len_q - IPV4_HDR_BYTES;
        n_in        = in_last_q ? keep_bytes(in_keep_q) : 4'd8;
        n_hi        = (n_in > 4'd4) ? 4'd4 : n_in;
        avail       = 4'd4 + n_hi;
        rem         = len_q - cnt_q;
        fits        = rem <= {12'd0, avail};
        out_beat    = {hold_q, in_dat_q[63:32]};
    end

`ifdef IP_RX_CHECKSUM_EN
    logic [15:0] csum_acc_q, csum_sum;

    ip_hdr_csum u_hdr_csum (
        .acc_i   ((state_q == ST_IDLE) ? 16'd0 : csum_acc_q),
        .dat_i   (in_dat_q),
        .lo_en_i (!(state_q == ST_HDR && hcnt_q == 2'd2)),
        .sum_o   (csum_sum)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            csum_acc_q <= '0;
        end else if (in_vld_q && (state_q == ST_IDLE || state_q == ST_HDR)) begin
            csum_acc_q <= csum_sum;
        end
    end

    assign csum_ok = (csum_sum == 16'hFFFF);
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            tot_len_q <= '0;
            hdr0_ok_q <= 1'b0;
            proto_q   <= '0;
            src_q     <= '0;
            hold_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            flush_n_q <= '0;
            dat_q     <= '0;
            user_q    <= '0;
            keep_q    <= 8'hFF;
            last_q    <= 1'b0;
            vld_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            keep_q <= 8'hFF;
            drop_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_vld_q) begin
                        tot_len_q <= in_dat_q[47:32];
                        hdr0_ok_q <= hdr0_ok;
                        hcnt_q    <= 2'd1;
                        if (in_last_q) begin
                            drop_q <= 1'b1;
                        end else begin
                            state_q <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (in_vld_q) begin
                        if (hcnt_q == 2'd1) begin
                            proto_q <= in_dat_q[55:48];
                            src_q   <= in_dat_q[31:0];
                            hcnt_q  <= 2'd2;
                            if (in_last_q) begin
                                drop_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            hold_q <= in_dat_q[31:0];
                            len_q  <= payload_len;
                            cnt_q  <= '0;
                            if (in_last_q || !accept) begin
                                drop_q  <= 1'b1;
                                state_q <= in_last_q ? ST_IDLE : ST_DROP;
                            end else begin
                                user_q[LEN_MSB -: 16]   <= payload_len;
                                user_q[PROTO_MSB -: 8]  <= proto_q;
                                user_q[SRCIP_MSB -: 32] <= src_q;
                                state_q <= ST_PAYLOAD;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (in_vld_q) begin
                        vld_q  <= 1'b1;
                        dat_q  <= out_beat;
                        hold_q <= in_dat_q[31:0];
                        cnt_q  <= cnt_q + 16'd8;
                        if (fits) begin
                            // Payload complete; any remaining input is Ethernet padding.
                            last_q  <= 1'b1;
                            keep_q  <= keep_mask(rem[3:0]);
                            state_q <= in_last_q ? ST_IDLE : ST_DROP;
                        end else if (in_last_q) begin
                            if (n_in > 4'd4) begin
                                flush_n_q <= 3'(n_in - 4'd4);
                                state_q   <= ST_FLUSH;
                            end else begin
                                last_q  <= 1'b1;
                                keep_q  <= keep_mask(avail);
                                drop_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    vld_q  <= 1'b1;
                    last_q <= 1'b1;
                    dat_q  <= {hold_q, 32'd0};
                    if (rem > {13'd0, flush_n_q}) begin
                        keep_q <= keep_mask({1'b0, flush_n_q});
                        drop_q <= 1'b1;
                    end else begin
                        keep_q <= keep_mask(rem[3:0]);
                    end
                    state_q <= ST_IDLE;
                end
                ST_DROP: begin
                    if (in_vld_q && in_last_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_ip_data  = dat_q;
    assign m_axis_ip_user  = user_q;
    assign m_axis_ip_keep  = keep_q;
    assign m_axis_ip_last  = last_q;
    assign m_axis_ip_valid = vld_q;
    assign o_drop          = drop_q;

endmodule
